// File: rtl/c7bbiu_pkg.sv
// Shared types for the BIU read arbiter: FSM state, requester id,
// captured request record and the default burst length.
package c7bbiu_pkg;

  localparam int LINE_BEATS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    ID_ICU = 1'b0,
    ID_DCU = 1'b1
  } req_id_t;

  // Request fields latched at grant time and replayed downstream.
  typedef struct packed {
    logic [31:3] addr;
    logic        single;
  } rd_req_t;

  // One-hot grant vector {dcu, icu} to requester id.
  function automatic req_id_t grant_id(input logic [1:0] g);
    return g[1] ? ID_DCU : ID_ICU;
  endfunction

endpackage

// File: rtl/c7bbiu_rd_arb_if.sv
// Requester and downstream bus signals of the read arbiter.
// slave  = the arbiter's view, master = the surrounding agents' view.
interface c7bbiu_rd_arb_if;

  logic        icu_biu_req;
  logic        dcu_biu_req;
  logic [31:3] icu_biu_addr;
  logic [31:3] dcu_biu_addr;
  logic        icu_biu_single;
  logic        dcu_biu_single;

  logic        biu_icu_ack;
  logic        biu_dcu_ack;
  logic        biu_icu_data_valid;
  logic        biu_icu_data_last;
  logic        biu_icu_fault;
  logic        biu_dcu_data_valid;
  logic        biu_dcu_data_last;
  logic        biu_dcu_fault;
  logic [63:0] biu_icu_data;
  logic [63:0] biu_dcu_data;

  logic        arb_bus_req;
  logic [31:3] arb_bus_addr;
  logic        arb_bus_single;

  logic        bus_arb_ack;
  logic        bus_arb_data_valid;
  logic        bus_arb_data_last;
  logic        bus_arb_fault;
  logic [63:0] bus_arb_data;

  logic        arb_busy;
  logic        arb_err;

  modport slave (
    input  icu_biu_req, dcu_biu_req, icu_biu_addr, dcu_biu_addr,
           icu_biu_single, dcu_biu_single,
    output biu_icu_ack, biu_dcu_ack,
           biu_icu_data_valid, biu_icu_data_last, biu_icu_fault,
           biu_dcu_data_valid, biu_dcu_data_last, biu_dcu_fault,
           biu_icu_data, biu_dcu_data,
    output arb_bus_req, arb_bus_addr, arb_bus_single,
    input  bus_arb_ack, bus_arb_data_valid, bus_arb_data_last,
           bus_arb_fault, bus_arb_data,
    output arb_busy, arb_err
  );

  modport master (
    output icu_biu_req, dcu_biu_req, icu_biu_addr, dcu_biu_addr,
           icu_biu_single, dcu_biu_single,
    input  biu_icu_ack, biu_dcu_ack,
           biu_icu_data_valid, biu_icu_data_last, biu_icu_fault,
           biu_dcu_data_valid, biu_dcu_data_last, biu_dcu_fault,
           biu_icu_data, biu_dcu_data,
    input  arb_bus_req, arb_bus_addr, arb_bus_single,
    output bus_arb_ack, bus_arb_data_valid, bus_arb_data_last,
           bus_arb_fault, bus_arb_data,
    input  arb_busy, arb_err
  );

endinterface

// File: rtl/c7bbiu_rr2.sv
// Two-way round-robin pick. Purely combinational; the caller keeps
// last_grant in a register. grant is {dcu, icu}, one-hot or zero.
module c7bbiu_rr2
  import c7bbiu_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  // Sole requester wins; a tie goes to whoever was not granted last.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == ID_ICU) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/c7bbiu_rd_arb.sv
// BIU read arbiter: picks ICU or DCU round-robin, replays the captured
// request downstream, routes the response beats to the owner and flags
// protocol errors (stray strobes, wrong burst length).
// LINE_BEATS is expected to be >= 2 so the saturating beat counter can
// tell an over-long burst from a correct one.
module c7bbiu_rd_arb
  import c7bbiu_pkg::*;
#(
  parameter int LINE_BEATS = LINE_BEATS_DEF
) (
  input logic            clk,
  input logic            reset,
  c7bbiu_rd_arb_if.slave bif
);

  localparam int            CW        = $clog2(LINE_BEATS) + 1;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] BURST_LEN = CW'(LINE_BEATS);
  localparam logic [CW-1:0] ONE_BEAT  = CW'(1);

  arb_state_t    state;
  req_id_t       owner;
  req_id_t       last_grant;
  rd_req_t       cur;
  logic [CW-1:0] beat_cnt;
  logic          busy_q;
  logic          bus_req_q;
  logic          out_en;

  logic [1:0]    req_vec;
  logic [1:0]    grant;
  rd_req_t       icu_rq;
  rd_req_t       dcu_rq;

  assign req_vec = {bif.dcu_biu_req, bif.icu_biu_req};
  assign icu_rq  = '{addr: bif.icu_biu_addr, single: bif.icu_biu_single};
  assign dcu_rq  = '{addr: bif.dcu_biu_addr, single: bif.dcu_biu_single};

  c7bbiu_rr2 u_rr2 (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  logic          in_idle;
  logic          in_req;
  logic          in_data;
  logic          beat;
  logic          done;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] exp_cnt;
  logic          len_err;
  logic          proto_err;
  logic          fwd_icu;
  logic          fwd_dcu;

  assign in_idle = (state == ST_IDLE);
  assign in_req  = (state == ST_REQ);
  assign in_data = (state == ST_DATA);
  assign beat    = in_data & bif.bus_arb_data_valid;
  assign done    = beat & bif.bus_arb_data_last;
  assign cnt_nxt = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + ONE_BEAT;
  assign exp_cnt = cur.single ? ONE_BEAT : BURST_LEN;
  assign len_err = done & (cnt_nxt != exp_cnt);

  // Strobes that have no meaning in the current state are dropped and
  // reported rather than routed.
  assign proto_err = (in_idle & (bif.bus_arb_ack | bif.bus_arb_data_valid |
                                 bif.bus_arb_data_last))
                   | (in_req  & (bif.bus_arb_data_valid | bif.bus_arb_data_last |
                                 bif.bus_arb_fault))
                   | (in_data & bif.bus_arb_ack);

  // out_en masks every combinational 1-bit output during reset and for
  // the first cycle after release.
  assign fwd_icu = out_en & in_data & (owner == ID_ICU);
  assign fwd_dcu = out_en & in_data & (owner == ID_DCU);

  assign bif.biu_icu_ack        = out_en & in_req & bif.bus_arb_ack & (owner == ID_ICU);
  assign bif.biu_dcu_ack        = out_en & in_req & bif.bus_arb_ack & (owner == ID_DCU);
  assign bif.biu_icu_data_valid = fwd_icu & bif.bus_arb_data_valid;
  assign bif.biu_icu_data_last  = fwd_icu & bif.bus_arb_data_last;
  assign bif.biu_icu_fault      = fwd_icu & bif.bus_arb_fault;
  assign bif.biu_dcu_data_valid = fwd_dcu & bif.bus_arb_data_valid;
  assign bif.biu_dcu_data_last  = fwd_dcu & bif.bus_arb_data_last;
  assign bif.biu_dcu_fault      = fwd_dcu & bif.bus_arb_fault;

  // Data is broadcast to both requesters; the valid strobe qualifies it.
  // Held at zero only while reset is asserted.
  assign bif.biu_icu_data = reset ? 64'd0 : bif.bus_arb_data;
  assign bif.biu_dcu_data = reset ? 64'd0 : bif.bus_arb_data;

  assign bif.arb_bus_req    = bus_req_q;
  assign bif.arb_bus_addr   = cur.addr;
  assign bif.arb_bus_single = cur.single;
  assign bif.arb_busy       = busy_q;
  assign bif.arb_err        = out_en & (proto_err | len_err);

  // Output enable: low in reset and one cycle beyond release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_en <= 1'b0;
    else       out_en <= 1'b1;
  end

  // Arbitration FSM with registered busy / bus request outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= ID_ICU;
      last_grant <= ID_DCU;
      cur        <= '0;
      beat_cnt   <= '0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner      <= grant_id(grant);
            last_grant <= grant_id(grant);
            cur        <= grant[1] ? dcu_rq : icu_rq;
            state      <= ST_REQ;
            busy_q     <= 1'b1;
            bus_req_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bif.bus_arb_ack) begin
            state     <= ST_DATA;
            beat_cnt  <= '0;
            bus_req_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (beat) beat_cnt <= cnt_nxt;
          if (done) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy_q    <= 1'b0;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c7bbiu_rd_arb.sv
// Scoreboard bench for c7bbiu_rd_arb: expected beats are queued as the
// bus model drives them and compared against beats seen at the requesters.
module tb_c7bbiu_rd_arb;
  import c7bbiu_pkg::*;

  typedef struct packed {
    logic        id;
    logic [63:0] data;
    logic        last;
    logic        fault;
  } beat_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    checks   = 0;
  int    failures = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    obs_rd = 0;

  always #5 clk = ~clk;

  c7bbiu_rd_arb_if bif ();

  c7bbiu_rd_arb #(.LINE_BEATS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif.slave)
  );

  // Record every routed beat, tagged with the requester it went to.
  always @(negedge clk) begin
    if (!reset) begin
      if (bif.biu_icu_data_valid)
        obs_q.push_back({1'b0, bif.biu_icu_data, bif.biu_icu_data_last, bif.biu_icu_fault});
      if (bif.biu_dcu_data_valid)
        obs_q.push_back({1'b1, bif.biu_dcu_data, bif.biu_dcu_data_last, bif.biu_dcu_fault});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] out_bits();
    return {bif.biu_icu_ack, bif.biu_dcu_ack,
            bif.biu_icu_data_valid, bif.biu_icu_data_last, bif.biu_icu_fault,
            bif.biu_dcu_data_valid, bif.biu_dcu_data_last, bif.biu_dcu_fault,
            bif.arb_bus_req, bif.arb_bus_single, bif.arb_busy, bif.arb_err};
  endfunction

  task automatic init_inputs();
    bif.icu_biu_req = 0; bif.dcu_biu_req = 0;
    bif.icu_biu_addr = '0; bif.dcu_biu_addr = '0;
    bif.icu_biu_single = 0; bif.dcu_biu_single = 0;
    bif.bus_arb_ack = 0; bif.bus_arb_data_valid = 0;
    bif.bus_arb_data_last = 0; bif.bus_arb_fault = 0;
    bif.bus_arb_data = '0;
  endtask

  task automatic set_req(input logic own, input logic v);
    if (own) bif.dcu_biu_req = v;
    else     bif.icu_biu_req = v;
  endtask

  task automatic observe(input logic own, inout int ack_own, inout int ack_oth, inout int errs);
    if (own) begin
      ack_own += int'(bif.biu_dcu_ack); ack_oth += int'(bif.biu_icu_ack);
    end else begin
      ack_own += int'(bif.biu_icu_ack); ack_oth += int'(bif.biu_dcu_ack);
    end
    errs += int'(bif.arb_err);
  endtask

  // Bus-side model: waits for arb_bus_req, acks after ack_dly REQ cycles,
  // then drives nbeats beats (last/fault on the given beat numbers).
  // Returns at the negedge of the cycle after the final beat.
  task automatic run_xfer(input logic own, input int ack_dly, input int nbeats,
                          input int last_at, input int fault_at,
                          input logic [63:0] base, input bit rereq,
                          output int ack_own, output int ack_oth, output int errs,
                          output int hold_bad, output logic [31:3] cap_addr,
                          output logic cap_single, output bit tmo);
    int w;
    ack_own = 0; ack_oth = 0; errs = 0; hold_bad = 0; tmo = 0; w = 0;
    cap_addr = '0; cap_single = 0;
    while (!bif.arb_bus_req && w < 40) begin
      @(negedge clk); w++;
    end
    if (!bif.arb_bus_req) begin
      tmo = 1;
      return;
    end
    cap_addr = bif.arb_bus_addr; cap_single = bif.arb_bus_single;
    repeat (ack_dly) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!bif.arb_bus_req || bif.arb_bus_addr !== cap_addr) hold_bad++;
      observe(own, ack_own, ack_oth, errs);
    end
    @(posedge clk); #1;
    bif.bus_arb_ack = 1;
    @(negedge clk);
    if (!bif.arb_bus_req || bif.arb_bus_addr !== cap_addr) hold_bad++;
    observe(own, ack_own, ack_oth, errs);
    @(posedge clk); #1;
    bif.bus_arb_ack = 0;
    set_req(own, 0);
    for (int b = 1; b <= nbeats; b++) begin
      bif.bus_arb_data_valid = 1;
      bif.bus_arb_data       = base + 64'(b - 1);
      bif.bus_arb_data_last  = (b == last_at);
      bif.bus_arb_fault      = (b == fault_at);
      exp_q.push_back({own, base + 64'(b - 1), logic'(b == last_at), logic'(b == fault_at)});
      if (rereq && b == nbeats) set_req(own, 1);
      @(negedge clk);
      observe(own, ack_own, ack_oth, errs);
      @(posedge clk); #1;
    end
    bif.bus_arb_data_valid = 0; bif.bus_arb_data_last = 0; bif.bus_arb_fault = 0;
    @(negedge clk);
    observe(own, ack_own, ack_oth, errs);
  endtask

  task automatic test_reset();
    init_inputs();
    reset = 1;
    bif.bus_arb_ack = 1; bif.bus_arb_data_valid = 1; bif.bus_arb_data_last = 1;
    bif.bus_arb_fault = 1; bif.bus_arb_data = 64'hDEAD_BEEF_0123_4567;
    @(negedge clk);
    checks++;
    if (out_bits() !== 12'd0) begin
      failures++; $display("FAIL reset_bits got=%b want=%b", out_bits(), 12'd0);
    end
    checks++;
    if (bif.biu_icu_data !== 64'd0 || bif.biu_dcu_data !== 64'd0 || bif.arb_bus_addr !== '0) begin
      failures++; $display("FAIL reset_buses icu=%h dcu=%h addr=%h want=0", bif.biu_icu_data, bif.biu_dcu_data, bif.arb_bus_addr);
    end
    @(posedge clk); #1;
    init_inputs();
    reset = 0;
    @(negedge clk);
    checks++;
    if (out_bits() !== 12'd0) begin
      failures++; $display("FAIL post_reset_bits got=%b want=%b", out_bits(), 12'd0);
    end
  endtask

  task automatic test_single_icu();
    int ao, ax, er, hb; logic [31:3] ca; logic cs; bit tm; beat_t e;
    @(posedge clk); #1;
    bif.icu_biu_req = 1; bif.icu_biu_addr = 29'h200; bif.icu_biu_single = 0;
    run_xfer(1'b0, 2, 4, 4, 0, 64'hA0, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm) begin failures++; $display("FAIL icu_timeout got=1 want=0"); end
    checks++; if (ca !== 29'h200 || cs !== 1'b0) begin
      failures++; $display("FAIL icu_bus_req addr=%h single=%b want addr=200 single=0", ca, cs); end
    checks++; if (ao != 1 || ax != 0) begin
      failures++; $display("FAIL icu_ack own=%0d other=%0d want 1/0", ao, ax); end
    checks++; if (er != 0) begin failures++; $display("FAIL icu_err got=%0d want=0", er); end
    checks++; if (bif.arb_busy !== 1'b0) begin failures++; $display("FAIL icu_idle busy=%b want=0", bif.arb_busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_rd >= obs_q.size()) begin failures++; $display("FAIL icu_beat missing want=%h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failures++; $display("FAIL icu_beat got=%h want=%h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin
      failures++; $display("FAIL icu_extra_beats got=%0d want=%0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_tie();
    int ao, ax, er, hb; logic [31:3] ca; logic cs; bit tm; beat_t e;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    bif.icu_biu_req = 1; bif.icu_biu_addr = 29'h1111; bif.icu_biu_single = 0;
    bif.dcu_biu_req = 1; bif.dcu_biu_addr = 29'h2222; bif.dcu_biu_single = 0;
    run_xfer(1'b0, 1, 4, 4, 0, 64'hB0, 1, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || ca !== 29'h1111) begin
      failures++; $display("FAIL tie_first tmo=%b addr=%h want addr=1111", tm, ca); end
    checks++; if (ao != 1 || ax != 0) begin
      failures++; $display("FAIL tie_first_ack own=%0d other=%0d want 1/0", ao, ax); end
    checks++; if (bif.arb_bus_req !== 1'b0) begin
      failures++; $display("FAIL tie_gap_n1 bus_req=%b want=0", bif.arb_bus_req); end
    @(negedge clk);
    checks++; if (bif.arb_bus_req !== 1'b1 || bif.arb_bus_addr !== 29'h2222) begin
      failures++; $display("FAIL tie_gap_n2 bus_req=%b addr=%h want 1/2222", bif.arb_bus_req, bif.arb_bus_addr); end
    run_xfer(1'b1, 0, 4, 4, 0, 64'hC0, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || ao != 1 || ax != 0 || er != 0) begin
      failures++; $display("FAIL tie_dcu tmo=%b ack=%0d other=%0d err=%0d want 0/1/0/0", tm, ao, ax, er); end
    run_xfer(1'b0, 0, 4, 4, 0, 64'hD0, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || ao != 1 || ca !== 29'h1111) begin
      failures++; $display("FAIL tie_icu_again tmo=%b ack=%0d addr=%h want 0/1/1111", tm, ao, ca); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_rd >= obs_q.size()) begin failures++; $display("FAIL tie_beat missing want=%h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failures++; $display("FAIL tie_beat got=%h want=%h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin
      failures++; $display("FAIL tie_extra_beats got=%0d want=%0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_dcu_single();
    int ao, ax, er, hb; logic [31:3] ca; logic cs; bit tm; beat_t e;
    @(posedge clk); #1;
    bif.dcu_biu_req = 1; bif.dcu_biu_addr = 29'h0ABC; bif.dcu_biu_single = 1;
    run_xfer(1'b1, 0, 1, 1, 0, 64'hE0, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || cs !== 1'b1 || ca !== 29'h0ABC) begin
      failures++; $display("FAIL dcu_single tmo=%b single=%b addr=%h want 0/1/0abc", tm, cs, ca); end
    checks++; if (ao != 1 || er != 0 || bif.arb_busy !== 1'b0) begin
      failures++; $display("FAIL dcu_single_end ack=%0d err=%0d busy=%b want 1/0/0", ao, er, bif.arb_busy); end
    @(posedge clk); #1;
    bif.dcu_biu_req = 1; bif.dcu_biu_addr = 29'h0BCD; bif.dcu_biu_single = 0;
    run_xfer(1'b1, 0, 2, 2, 0, 64'hF0, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || er != 1) begin
      failures++; $display("FAIL short_burst_err tmo=%b err_pulses=%0d want 0/1", tm, er); end
    checks++; if (bif.arb_busy !== 1'b0) begin
      failures++; $display("FAIL short_burst_idle busy=%b want=0", bif.arb_busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_rd >= obs_q.size()) begin failures++; $display("FAIL dcu_beat missing want=%h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failures++; $display("FAIL dcu_beat got=%h want=%h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin
      failures++; $display("FAIL dcu_extra_beats got=%0d want=%0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_fault();
    int ao, ax, er, hb; logic [31:3] ca; logic cs; bit tm; beat_t e;
    @(posedge clk); #1;
    bif.icu_biu_req = 1; bif.icu_biu_addr = 29'h0300; bif.icu_biu_single = 0;
    run_xfer(1'b0, 1, 4, 4, 2, 64'h50, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || er != 0 || bif.arb_busy !== 1'b0) begin
      failures++; $display("FAIL fault_xfer tmo=%b err=%0d busy=%b want 0/0/0", tm, er, bif.arb_busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_rd >= obs_q.size()) begin failures++; $display("FAIL fault_beat missing want=%h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failures++; $display("FAIL fault_beat got=%h want=%h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin
      failures++; $display("FAIL fault_extra_beats got=%0d want=%0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_reset_mid();
    int w; beat_t e;
    w = 0;
    @(posedge clk); #1;
    bif.icu_biu_req = 1; bif.icu_biu_addr = 29'h0400; bif.icu_biu_single = 0;
    while (!bif.arb_bus_req && w < 40) begin @(negedge clk); w++; end
    checks++; if (!bif.arb_bus_req) begin failures++; $display("FAIL rstmid_timeout bus_req=0 want=1"); end
    @(posedge clk); #1; bif.bus_arb_ack = 1;
    @(posedge clk); #1; bif.bus_arb_ack = 0; bif.icu_biu_req = 0;
    for (int b = 0; b < 2; b++) begin
      bif.bus_arb_data_valid = 1; bif.bus_arb_data = 64'h70 + 64'(b);
      exp_q.push_back({1'b0, 64'h70 + 64'(b), 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    bif.bus_arb_data_valid = 0;
    reset = 1;
    #1;
    checks++; if (bif.arb_busy !== 1'b0 || bif.arb_bus_req !== 1'b0) begin
      failures++; $display("FAIL rstmid_immediate busy=%b bus_req=%b want 0/0", bif.arb_busy, bif.arb_bus_req); end
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    checks++; if (bif.arb_busy !== 1'b0) begin failures++; $display("FAIL rstmid_release busy=%b want=0", bif.arb_busy); end
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bif.bus_arb_data_valid = 1; bif.bus_arb_data_last = (b == 1); bif.bus_arb_data = 64'h99;
      @(negedge clk);
      checks++; if (bif.arb_err !== 1'b1 || bif.biu_icu_data_valid !== 1'b0 || bif.biu_dcu_data_valid !== 1'b0) begin
        failures++; $display("FAIL stray_beat err=%b icu_v=%b dcu_v=%b want 1/0/0", bif.arb_err, bif.biu_icu_data_valid, bif.biu_dcu_data_valid); end
    end
    @(posedge clk); #1;
    bif.bus_arb_data_valid = 0; bif.bus_arb_data_last = 0;
    @(negedge clk);
    checks++; if (bif.arb_busy !== 1'b0) begin failures++; $display("FAIL stray_no_resume busy=%b want=0", bif.arb_busy); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_rd >= obs_q.size()) begin failures++; $display("FAIL rstmid_beat missing want=%h", e); end
      else begin
        if (obs_q[obs_rd] !== e) begin failures++; $display("FAIL rstmid_beat got=%h want=%h", obs_q[obs_rd], e); end
        obs_rd++;
      end
    end
    checks++; if (obs_rd != obs_q.size()) begin
      failures++; $display("FAIL rstmid_extra_beats got=%0d want=%0d", obs_q.size(), obs_rd); obs_rd = obs_q.size(); end
  endtask

  task automatic test_owner_drop();
    int ao, ax, er, hb, w; logic [31:3] ca; logic cs; bit tm;
    w = 0;
    @(posedge clk); #1;
    bif.icu_biu_req = 1; bif.icu_biu_addr = 29'h0555; bif.icu_biu_single = 0;
    while (!bif.arb_bus_req && w < 40) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    bif.icu_biu_req = 0; bif.icu_biu_addr = 29'h1FFF_FFFF; bif.icu_biu_single = 1;
    run_xfer(1'b0, 3, 4, 4, 0, 64'h30, 0, ao, ax, er, hb, ca, cs, tm);
    checks++; if (tm || hb != 0) begin
      failures++; $display("FAIL drop_hold tmo=%b bad_cycles=%0d want 0/0", tm, hb); end
    checks++; if (ca !== 29'h0555 || cs !== 1'b0 || ao != 1) begin
      failures++; $display("FAIL drop_capture addr=%h single=%b ack=%0d want 0555/0/1", ca, cs, ao); end
    exp_q.delete();
    obs_rd = obs_q.size();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_icu();
    test_tie();
    test_dcu_single();
    test_fault();
    test_reset_mid();
    test_owner_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
